// File: rtl/grade_pkg.sv
// Shared types and defaults for the streamed grade evaluator.
// Holds FSM states, verdict bundle and sum-width helper.
package grade_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESULT
  } state_t;

  localparam int DEF_NUM_SECT  = 4;
  localparam int DEF_GRADE_W   = 8;
  localparam int DEF_MAX_GRADE = 100;
  localparam int DEF_PASS_TH   = 100;
  localparam int DEF_SCHOL_TH  = 200;
  localparam int DEF_CNT_W     = 8;

  typedef struct packed {
    logic failed;
    logic passed;
    logic scholarship;
    logic bad_grade;
  } verdict_t;

  function automatic int sum_w(input int gw, input int ns);
    return gw + $clog2(ns);
  endfunction

endpackage

// File: rtl/grade_eval_sequencer_if.sv
// Grade stream, verdict handshake and statistics bundle.
// master = source/consumer side, slave = sequencer.
interface grade_eval_sequencer_if
  import grade_pkg::*;
#(
  parameter int GRADE_W = DEF_GRADE_W,
  parameter int SUM_W   = sum_w(DEF_GRADE_W, DEF_NUM_SECT),
  parameter int CNT_W   = DEF_CNT_W
);
  logic               grade_valid;
  logic               grade_ready;
  logic [GRADE_W-1:0] grade_in;
  logic               abort;
  logic               result_valid;
  logic               result_ready;
  logic [SUM_W-1:0]   sum_out;
  logic               failed;
  logic               passed;
  logic               scholarship;
  logic               bad_grade;
  logic [CNT_W-1:0]   n_failed;
  logic [CNT_W-1:0]   n_passed;
  logic [CNT_W-1:0]   n_schol;

  modport master (
    output grade_valid, grade_in, abort, result_ready,
    input  grade_ready, result_valid, sum_out,
    input  failed, passed, scholarship, bad_grade,
    input  n_failed, n_passed, n_schol
  );

  modport slave (
    input  grade_valid, grade_in, abort, result_ready,
    output grade_ready, result_valid, sum_out,
    output failed, passed, scholarship, bad_grade,
    output n_failed, n_passed, n_schol
  );
endinterface

// File: rtl/grade_verdict.sv
// Combinational verdict from a record sum and bad flag.
// Shared with the parallel evaluator.
module grade_verdict
  import grade_pkg::*;
#(
  parameter int SUM_W    = sum_w(DEF_GRADE_W, DEF_NUM_SECT),
  parameter int PASS_TH  = DEF_PASS_TH,
  parameter int SCHOL_TH = DEF_SCHOL_TH
) (
  input  logic [SUM_W-1:0] i_sum,
  input  logic             i_bad,
  output verdict_t         o_verdict
);
  always_comb begin
    o_verdict           = '0;
    o_verdict.bad_grade = i_bad;
    if (i_bad) begin
      o_verdict.failed = 1'b1;
    end else begin
      o_verdict.failed      = int'(i_sum) <  PASS_TH;
      o_verdict.passed      = int'(i_sum) >= PASS_TH;
      o_verdict.scholarship = int'(i_sum) >= SCHOL_TH;
    end
  end
endmodule

// File: rtl/grade_eval_sequencer.sv
// Streams NUM_SECT grades per record and holds a registered verdict.
// Define GRADE_EVAL_STATS_EN to build the saturating verdict counters.
module grade_eval_sequencer
  import grade_pkg::*;
#(
  parameter int NUM_SECT  = DEF_NUM_SECT,
  parameter int GRADE_W   = DEF_GRADE_W,
  parameter int MAX_GRADE = DEF_MAX_GRADE,
  parameter int PASS_TH   = DEF_PASS_TH,
  parameter int SCHOL_TH  = DEF_SCHOL_TH,
  parameter int CNT_W     = DEF_CNT_W
) (
  input logic                   clk,
  input logic                   rst,
  grade_eval_sequencer_if.slave bus
);
  localparam int SUM_W = sum_w(GRADE_W, NUM_SECT);
  localparam int IDX_W = $clog2(NUM_SECT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SECT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SUM_W-1:0] r_acc;
  logic [SUM_W-1:0] r_sum;
  logic [IDX_W-1:0] r_idx;
  logic             r_bad;
  verdict_t         r_vd;
  verdict_t         w_vd;
  logic [SUM_W-1:0] w_sum_nxt;
  logic             w_bad_nxt;
  logic             w_xfer;
  logic             w_res_hs;
  logic             w_acc_en;
  logic             w_load;
  logic             w_clr;

  assign bus.grade_ready  = (r_state != RESULT);
  assign bus.result_valid = (r_state == RESULT);
  assign w_xfer   = bus.grade_valid & bus.grade_ready;
  assign w_res_hs = bus.result_valid & bus.result_ready;

  // IDLE starts a fresh record regardless of leftover accumulator state
  assign w_sum_nxt = ((r_state == ACCUM) ? r_acc : '0)
                   + SUM_W'(bus.grade_in);
  assign w_bad_nxt = ((r_state == ACCUM) & r_bad)
                   | (int'(bus.grade_in) > MAX_GRADE);

  grade_verdict #(
    .SUM_W    (SUM_W),
    .PASS_TH  (PASS_TH),
    .SCHOL_TH (SCHOL_TH)
  ) u_verdict (
    .i_sum     (w_sum_nxt),
    .i_bad     (w_bad_nxt),
    .o_verdict (w_vd)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_acc_en    = 1'b0;
    w_load      = 1'b0;
    w_clr       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.abort) begin
          w_clr = 1'b1;
        end else if (w_xfer) begin
          w_acc_en    = 1'b1;
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.abort) begin
          w_clr       = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_xfer) begin
          if (r_idx == LAST_IDX) begin
            w_load      = 1'b1;
            w_state_nxt = RESULT;
          end else begin
            w_acc_en = 1'b1;
          end
        end
      end
      RESULT: begin
        if (w_res_hs) begin
          w_clr       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_idx <= '0;
      r_bad <= 1'b0;
      r_sum <= '0;
      r_vd  <= '0;
    end else begin
      if (w_clr) begin
        r_acc <= '0;
        r_idx <= '0;
        r_bad <= 1'b0;
      end else if (w_acc_en) begin
        r_acc <= w_sum_nxt;
        r_idx <= r_idx + 1'b1;
        r_bad <= w_bad_nxt;
      end
      if (w_load) begin
        r_sum <= w_sum_nxt;
        r_vd  <= w_vd;
      end
    end
  end

  assign bus.sum_out     = r_sum;
  assign bus.failed      = r_vd.failed;
  assign bus.passed      = r_vd.passed;
  assign bus.scholarship = r_vd.scholarship;
  assign bus.bad_grade   = r_vd.bad_grade;

`ifdef GRADE_EVAL_STATS_EN
  logic [CNT_W-1:0] r_nf;
  logic [CNT_W-1:0] r_np;
  logic [CNT_W-1:0] r_ns;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nf <= '0;
      r_np <= '0;
      r_ns <= '0;
    end else if (w_res_hs) begin
      if (r_vd.failed && (r_nf != '1))
        r_nf <= r_nf + 1'b1;
      if (r_vd.passed && (r_np != '1))
        r_np <= r_np + 1'b1;
      if (r_vd.scholarship && (r_ns != '1))
        r_ns <= r_ns + 1'b1;
    end
  end

  assign bus.n_failed = r_nf;
  assign bus.n_passed = r_np;
  assign bus.n_schol  = r_ns;
`else
  assign bus.n_failed = {CNT_W{1'b0}};
  assign bus.n_passed = {CNT_W{1'b0}};
  assign bus.n_schol  = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_grade_eval_sequencer.sv
// Directed bench for grade_eval_sequencer.
// Expected sums and verdicts are hand-computed per record.
module tb_grade_eval_sequencer;
  import grade_pkg::*;

  localparam int GW = 8;
  localparam int NS = 4;
  localparam int SW = sum_w(GW, NS);
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  grade_eval_sequencer_if #(
    .GRADE_W (GW),
    .SUM_W   (SW),
    .CNT_W   (CW)
  ) bus ();

  grade_eval_sequencer #(
    .NUM_SECT  (NS),
    .GRADE_W   (GW),
    .MAX_GRADE (100),
    .PASS_TH   (100),
    .SCHOL_TH  (200),
    .CNT_W     (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input int g);
    chk("grade_ready", 32'(bus.grade_ready), 1);
    bus.grade_valid = 1'b1;
    bus.grade_in    = 8'(g);
    @(posedge clk);
    #1;
    bus.grade_valid = 1'b0;
  endtask

  task automatic rec(input int a, input int b,
                     input int c, input int d);
    send(a);
    send(b);
    send(c);
    chk("rv_early", 32'(bus.result_valid), 0);
    send(d);
    chk("rv_latency", 32'(bus.result_valid), 1);
    chk("gr_in_result", 32'(bus.grade_ready), 0);
  endtask

  task automatic chk_vd(input int s, input int f, input int p,
                        input int sc, input int b);
    chk("sum_out", 32'(bus.sum_out), 32'(s));
    chk("failed", 32'(bus.failed), 32'(f));
    chk("passed", 32'(bus.passed), 32'(p));
    chk("scholarship", 32'(bus.scholarship), 32'(sc));
    chk("bad_grade", 32'(bus.bad_grade), 32'(b));
  endtask

  task automatic chk_cnt(input int f, input int p, input int s);
`ifdef GRADE_EVAL_STATS_EN
    chk("n_failed", 32'(bus.n_failed), 32'(f));
    chk("n_passed", 32'(bus.n_passed), 32'(p));
    chk("n_schol", 32'(bus.n_schol), 32'(s));
`else
    chk("n_failed", 32'(bus.n_failed), 0);
    chk("n_passed", 32'(bus.n_passed), 0);
    chk("n_schol", 32'(bus.n_schol), 0);
    if (f + p + s < 0) $display("unreachable");
`endif
  endtask

  task automatic handshake();
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.result_ready = 1'b0;
    chk("rv_after_hs", 32'(bus.result_valid), 0);
    chk("gr_after_hs", 32'(bus.grade_ready), 1);
  endtask

  initial begin
    bus.grade_valid  = 1'b0;
    bus.grade_in     = '0;
    bus.abort        = 1'b0;
    bus.result_ready = 1'b0;

    #2;
    chk("rst_gr", 32'(bus.grade_ready), 1);
    chk("rst_rv", 32'(bus.result_valid), 0);
    chk_vd(0, 0, 0, 0, 0);
    chk_cnt(0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    rec(0, 10, 30, 20);
    chk_vd(60, 1, 0, 0, 0);
    handshake();

    bus.result_ready = 1'b1;
    rec(25, 25, 25, 25);
    chk_vd(100, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    chk("b2b_gr1", 32'(bus.grade_ready), 1);
    chk("b2b_rv1", 32'(bus.result_valid), 0);
    rec(50, 50, 50, 50);
    chk_vd(200, 0, 1, 1, 0);
    @(posedge clk);
    #1;
    chk("b2b_gr2", 32'(bus.grade_ready), 1);
    bus.result_ready = 1'b0;

    rec(62, 81, 37, 19);
    for (int i = 0; i < 5; i++) begin
      bus.grade_valid = 1'b1;
      bus.grade_in    = 8'd7;
      bus.abort       = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_rv", 32'(bus.result_valid), 1);
      chk("hold_gr", 32'(bus.grade_ready), 0);
      chk_vd(199, 0, 1, 0, 0);
    end
    bus.grade_valid = 1'b0;
    bus.abort       = 1'b0;
    handshake();
    chk("sum_kept", 32'(bus.sum_out), 199);

    rec(62, 50, 11, 112);
    chk_vd(235, 1, 0, 0, 1);
    handshake();
    chk_cnt(2, 3, 1);

    send(40);
    send(16);
    bus.abort       = 1'b1;
    bus.grade_valid = 1'b1;
    bus.grade_in    = 8'd5;
    @(posedge clk);
    #1;
    bus.abort       = 1'b0;
    bus.grade_valid = 1'b0;
    chk("abort_rv", 32'(bus.result_valid), 0);
    rec(25, 25, 25, 25);
    chk_vd(100, 0, 1, 0, 0);
    handshake();
    chk_cnt(2, 4, 1);

    send(30);
    send(40);
    rst = 1'b1;
    #1;
    chk("arst_gr", 32'(bus.grade_ready), 1);
    chk("arst_rv", 32'(bus.result_valid), 0);
    chk_vd(0, 0, 0, 0, 0);
    chk_cnt(0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rec(10, 10, 10, 10);
    chk_vd(40, 1, 0, 0, 0);
    handshake();
    chk_cnt(1, 0, 0);

`ifdef GRADE_EVAL_STATS_EN
    bus.result_ready = 1'b1;
    for (int r = 0; r < 300; r++) begin
      for (int k = 0; k < NS; k++) begin
        bus.grade_valid = 1'b1;
        bus.grade_in    = 8'd1;
        @(posedge clk);
        #1;
      end
      bus.grade_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.result_ready = 1'b0;
    chk_cnt(255, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
